// File: rtl/pipe_ctrl_chain.sv
// E/M/W control-bundle pipeline with per-stage valid, bubble insertion and an
// MDU occupancy tracker that stalls PC/F/D while a mult/div is in flight.
module pipe_ctrl_chain #(
  parameter int CTRL_W  = 16,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic              validD,
  input  logic              mdu_startD,
  input  logic              mdu_is_divD,
  input  logic              mdu_readD,
  input  logic              stallD,
  input  logic              flushE,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [CTRL_W-1:0] ctrlM,
  output logic [CTRL_W-1:0] ctrlW,
  output logic              validE,
  output logic              validM,
  output logic              validW,
  output logic              mdu_busy,
  output logic              mdu_stall,
  output logic              mdu_done
);

  localparam int STAGES = 3;
  localparam int CNT_W  = $clog2(DIV_LAT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  logic [STAGES:1][CTRL_W-1:0] ctrl_pipe;
  logic [STAGES:1]             vld_pipe;
  logic                        bubble;
  logic                        accept;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             done_nxt;

  assign bubble = flushE | stallD | mdu_stall;
  assign accept = validD & mdu_startD & ~bubble;

  // Stage 1 (E) takes D or a bubble; M and W shift unconditionally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_pipe <= '0;
      vld_pipe  <= '0;
    end else begin
      ctrl_pipe[1] <= bubble ? '0 : ctrlD;
      vld_pipe[1]  <= bubble ? 1'b0 : validD;
      ctrl_pipe[STAGES:2] <= ctrl_pipe[STAGES-1:1];
      vld_pipe[STAGES:2]  <= vld_pipe[STAGES-1:1];
    end
  end

  assign ctrlE  = ctrl_pipe[1];
  assign ctrlM  = ctrl_pipe[2];
  assign ctrlW  = ctrl_pipe[3];
  assign validE = vld_pipe[1];
  assign validM = vld_pipe[2];
  assign validW = vld_pipe[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      mdu_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      mdu_done <= done_nxt;
    end
  end

  // count is loaded only from IDLE and leaves BUSY at 1, so it never wraps.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = BUSY;
        count_nxt = mdu_is_divD ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end
      BUSY: if (count == CNT_W'(1)) begin
        state_nxt = IDLE;
        count_nxt = '0;
        done_nxt  = 1'b1;
      end else begin
        count_nxt = count - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mdu_busy  = (state == BUSY);
    mdu_stall = validD & (mdu_startD | mdu_readD) & mdu_busy;
  end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: pipeline latency, bubbles, MDU
// mult/div occupancy, back-to-back ops, flush and async reset mid-op.
module tb_pipe_ctrl_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ctrlD;
  logic        validD, mdu_startD, mdu_is_divD, mdu_readD, stallD, flushE;
  logic [15:0] ctrlE, ctrlM, ctrlW;
  logic        validE, validM, validW, mdu_busy, mdu_stall, mdu_done;

  int total = 0;
  int bad   = 0;
  logic seen_done;

  pipe_ctrl_chain #(.CTRL_W(16), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset), .ctrlD(ctrlD), .validD(validD),
    .mdu_startD(mdu_startD), .mdu_is_divD(mdu_is_divD), .mdu_readD(mdu_readD),
    .stallD(stallD), .flushE(flushE),
    .ctrlE(ctrlE), .ctrlM(ctrlM), .ctrlW(ctrlW),
    .validE(validE), .validM(validM), .validW(validW),
    .mdu_busy(mdu_busy), .mdu_stall(mdu_stall), .mdu_done(mdu_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ctrlD = '0; validD = 0; mdu_startD = 0; mdu_is_divD = 0;
    mdu_readD = 0; stallD = 0; flushE = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #12;
    chk("rst_ctrlE", ctrlE, 0); chk("rst_ctrlW", ctrlW, 0);
    chk("rst_valid", {validE, validM, validW}, 0);
    chk("rst_busy", mdu_busy, 0); chk("rst_done", mdu_done, 0);
    @(negedge clk); reset = 0;
    step();

    // D->E->M->W latency
    ctrlD = 16'hA5A5; validD = 1;
    step();
    chk("lat_ctrlE", ctrlE, 16'hA5A5); chk("lat_validE", validE, 1);
    ctrlD = 16'h0000; validD = 0;
    step();
    chk("lat_ctrlM", ctrlM, 16'hA5A5); chk("lat_validM", validM, 1);
    chk("lat_ctrlE0", ctrlE, 0); chk("lat_validE0", validE, 0);
    step();
    chk("lat_ctrlW", ctrlW, 16'hA5A5); chk("lat_validW", validW, 1);

    // stallD bubble, FSM untouched despite a start in D
    ctrlD = 16'h1234; validD = 1; stallD = 1; mdu_startD = 1;
    step();
    chk("stl_ctrlE", ctrlE, 0); chk("stl_validE", validE, 0);
    chk("stl_busy", mdu_busy, 0);
    idle_inputs();
    step();
    chk("stl_validM", validM, 0); chk("stl_ctrlM", ctrlM, 0);
    step();
    chk("stl_validW", validW, 0);

    // mult, then mflo stalled for 4 busy cycles
    ctrlD = 16'h0011; validD = 1; mdu_startD = 1;
    step();
    chk("mul_busy0", mdu_busy, 1); chk("mul_ctrlE", ctrlE, 16'h0011);
    mdu_startD = 0; mdu_readD = 1; ctrlD = 16'h0022;
    for (int i = 0; i < 4; i++) begin
      chk("mul_stall", mdu_stall, 1); chk("mul_busy", mdu_busy, 1);
      chk("mul_nodone", mdu_done, 0);
      step();
      chk("mul_bubbleE", {ctrlE, 15'b0, validE}, 0);
    end
    chk("mul_done", mdu_done, 1); chk("mul_idle", mdu_busy, 0);
    chk("mul_nostall", mdu_stall, 0);
    step();
    chk("mflo_ctrlE", ctrlE, 16'h0022); chk("mflo_validE", validE, 1);
    chk("mul_done_off", mdu_done, 0);
    idle_inputs();
    step();

    // div, then a mult waits 32 cycles and is accepted on the done cycle
    ctrlD = 16'h0D0D; validD = 1; mdu_startD = 1; mdu_is_divD = 1;
    step();
    chk("div_busy0", mdu_busy, 1); chk("div_ctrlE", ctrlE, 16'h0D0D);
    mdu_is_divD = 0; ctrlD = 16'h0055;
    for (int i = 0; i < 32; i++) begin
      chk("div_stall", mdu_stall, 1); chk("div_busy", mdu_busy, 1);
      step();
    end
    chk("div_done", mdu_done, 1); chk("div_idle", mdu_busy, 0);
    chk("b2b_nostall", mdu_stall, 0);
    step();
    chk("b2b_busy", mdu_busy, 1); chk("b2b_ctrlE", ctrlE, 16'h0055);
    chk("b2b_done_off", mdu_done, 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b2b_busy_n", mdu_busy, 1);
    end
    step();
    chk("b2b_done", mdu_done, 1); chk("b2b_idle", mdu_busy, 0);

    // flushed mult never sets busy
    ctrlD = 16'h0077; validD = 1; mdu_startD = 1; flushE = 1;
    step();
    chk("fl_busy", mdu_busy, 0); chk("fl_ctrlE", ctrlE, 0); chk("fl_validE", validE, 0);
    idle_inputs();
    step();
    chk("fl_busy2", mdu_busy, 0);

    // div, fill pipeline with FFFF, async reset at count=10
    validD = 1; mdu_startD = 1; mdu_is_divD = 1; ctrlD = 16'h0101;
    step();
    mdu_startD = 0; mdu_is_divD = 0; ctrlD = 16'hFFFF;
    for (int i = 0; i < 22; i++) step();
    chk("pre_rst_busy", mdu_busy, 1); chk("pre_rst_ctrlW", ctrlW, 16'hFFFF);
    chk("pre_rst_valid", {validE, validM, validW}, 3'b111);
    #2 reset = 1;
    #1;
    chk("arst_ctrl", {ctrlE, ctrlM, ctrlW}, 0);
    chk("arst_valid", {validE, validM, validW}, 0);
    chk("arst_busy", mdu_busy, 0);
    idle_inputs();
    @(negedge clk); reset = 0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mdu_done) seen_done = 1;
    end
    chk("arst_nodone", seen_done, 0); chk("arst_idle", mdu_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
